// File: rtl/lsu_align_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_unit_pkg
// Description : Shared funct3 codes, FSM state encoding and access-size
//               decode helpers for the load/store alignment unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_align_unit_pkg;

    // RV32I load/store width codes (stores use only B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Straddling accesses spend one extra cycle in ST_SECOND
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } lsu_state_t;

    // Access size in bytes; only meaningful for legal funct3 values
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Loads accept B/H/W/BU/HU, stores accept B/H/W only
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // True when the access crosses into the next word
    function automatic logic straddles(input logic [1:0] off, input logic [2:0] size);
        return ({2'b00, off} + {1'b0, size}) > 4'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_unit_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_unit_lane_merge
// Description : Combinational byte-lane datapath. Loads: align and sign/zero
//               extend. Stores: insert data bytes into the read word for
//               read-modify-write. Handles the first (or only) half and the
//               second half of a straddling access.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align_unit_lane_merge
    import lsu_align_unit_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_size,
    input  logic        i_second,
    input  logic        i_sign_ext,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_hold,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    // Bytes already handled by the first half of a straddling access
    logic [2:0]  w_n1;
    logic [31:0] w_raw;
    logic [31:0] w_ins;
    logic [3:0]  w_lo;
    logic [3:0]  w_hi;

    assign w_n1 = 3'd4 - {1'b0, i_offset};

    // Second half: held upper bytes of word A sit below the low bytes of word B
    assign w_raw = i_second ? (i_hold | (i_rd_word << {w_n1, 3'b000}))
                            : (i_rd_word >> {i_offset, 3'b000});

    // Store bytes moved to their destination lanes for this half
    assign w_ins = i_second ? (i_wdata >> {w_n1, 3'b000})
                            : (i_wdata << {i_offset, 3'b000});

    // Lane window [w_lo, w_hi) receives store data; lanes past 3 are simply absent
    assign w_lo = i_second ? 4'd0 : {2'b00, i_offset};
    assign w_hi = i_second ? ({2'b00, i_offset} + {1'b0, i_size} - 4'd4)
                           : ({2'b00, i_offset} + {1'b0, i_size});

    // Truncate the aligned load to its size and extend
    always_comb begin
        case (i_size)
            3'd1:    o_load_data = {{24{i_sign_ext & w_raw[7]}},  w_raw[7:0]};
            3'd2:    o_load_data = {{16{i_sign_ext & w_raw[15]}}, w_raw[15:0]};
            default: o_load_data = w_raw;
        endcase
    end

    // Replace only the target lanes, keep the rest of the memory word
    always_comb begin
        o_store_word = i_rd_word;
        for (int i = 0; i < 4; i++) begin
            if ((4'(i) >= w_lo) && (4'(i) < w_hi))
                o_store_word[8*i +: 8] = w_ins[8*i +: 8];
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_unit
// Description : Load/store alignment unit in front of a word-only memory.
//               Sub-word extraction/extension, read-modify-write for SB/SH,
//               and two-cycle splitting of word-straddling accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align_unit
    import lsu_align_unit_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        fault,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t  r_state;
    logic [31:0] r_hold;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_we;

    logic        w_second;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_f3;
    logic        w_we;
    logic [2:0]  w_size;
    logic        w_legal;
    logic        w_strad;
    logic        w_split_start;
    logic [31:0] w_word_a;
    logic [31:0] w_word_b;
    logic [31:0] w_load;
    logic [31:0] w_store;

    // In SECOND the latched request drives everything; req_* is ignored
    assign w_second = (r_state == ST_SECOND);
    assign w_addr   = w_second ? r_addr   : req_addr;
    assign w_wdata  = w_second ? r_wdata  : req_wdata;
    assign w_f3     = w_second ? r_funct3 : req_funct3;
    assign w_we     = w_second ? r_we     : req_we;

    assign w_size   = f3_size(w_f3);
    assign w_legal  = f3_legal(w_we, w_f3);
    assign w_strad  = straddles(w_addr[1:0], w_size);
    assign w_word_a = {w_addr[31:2], 2'b00};
    assign w_word_b = w_word_a + 32'd4;

    assign w_split_start = req_valid && w_legal && w_strad && MISALIGN_EN;

    lsu_align_unit_lane_merge u_lane_merge (
        .i_offset     (w_addr[1:0]),
        .i_size       (w_size),
        .i_second     (w_second),
        .i_sign_ext   (~w_f3[2]),
        .i_rd_word    (mem_rd),
        .i_hold       (r_hold),
        .i_wdata      (w_wdata),
        .o_load_data  (w_load),
        .o_store_word (w_store)
    );

    // Response and memory-side outputs; all forced low while reset is held
    always_comb begin
        busy      = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'd0;
        fault     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wd    = 32'd0;
        if (rst_n) begin
            if (w_second) begin
                mem_addr  = w_word_b;
                rsp_valid = 1'b1;
                if (r_we) begin
                    mem_we = 1'b1;
                    mem_wd = w_store;
                end else begin
                    rsp_rdata = w_load;
                end
            end else if (req_valid) begin
                if (!w_legal || (w_strad && !MISALIGN_EN)) begin
                    fault     = 1'b1;
                    rsp_valid = 1'b1;
                end else begin
                    mem_addr  = w_word_a;
                    busy      = w_strad;
                    rsp_valid = !w_strad;
                    if (req_we) begin
                        mem_we = 1'b1;
                        mem_wd = w_store;
                    end else if (!w_strad) begin
                        rsp_rdata = w_load;
                    end
                end
            end
        end
    end

    // Split FSM: latch the request and the upper bytes of word A on entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_hold   <= 32'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_we     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_split_start) begin
                        r_state  <= ST_SECOND;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_we     <= req_we;
                        r_hold   <= req_we ? 32'd0 : (mem_rd >> {req_addr[1:0], 3'b000});
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_align_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_align_unit
// Description : Self-checking bench: byte-addressed reference memory model,
//               directed cases plus randomized loads/stores.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy, rsp_valid, fault, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;
    logic        nf_busy, nf_rsp_valid, nf_fault, nf_mem_we;
    logic [31:0] nf_rsp_rdata, nf_mem_addr, nf_mem_wd, nf_mem_rd;

    logic [31:0] mem [16];
    logic [7:0]  rmem [64];
    logic        bk_we;
    logic [3:0]  bk_idx;
    logic [31:0] bk_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_align_unit #(.MISALIGN_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fault(fault),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    lsu_align_unit #(.MISALIGN_EN(1'b0)) u_dut_nf (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(nf_busy), .rsp_valid(nf_rsp_valid), .rsp_rdata(nf_rsp_rdata), .fault(nf_fault),
        .mem_we(nf_mem_we), .mem_addr(nf_mem_addr), .mem_wd(nf_mem_wd), .mem_rd(nf_mem_rd)
    );

    // Word memory: async read, sync write; backdoor port for initialisation
    assign mem_rd    = mem[mem_addr[5:2]];
    assign nf_mem_rd = mem[nf_mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_addr[5:2]] <= mem_wd;
        else if (bk_we)
            mem[bk_idx] <= bk_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sz(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        logic [31:0] a;
        int s;
        v = 32'd0;
        s = sz(f3);
        for (int k = 0; k < s; k++) begin
            a = addr + 32'(k);
            v = v | (32'(rmem[a[5:0]]) << (8 * k));
        end
        if (!f3[2] && s == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && s == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [31:0] wd, input int nbytes);
        logic [31:0] a;
        for (int k = 0; k < nbytes; k++) begin
            a = addr + 32'(k);
            rmem[a[5:0]] = wd[8*k +: 8];
        end
    endtask

    task automatic bk_write(input logic [3:0] idx, input logic [31:0] data);
        bk_we   = 1'b1;
        bk_idx  = idx;
        bk_data = data;
        for (int k = 0; k < 4; k++) rmem[{idx, 2'(k)}] = data[8*k +: 8];
        @(posedge clk);
        #1 bk_we = 1'b0;
    endtask

    task automatic compare_mem();
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("mem[%0d]", i), mem[i],
                     {rmem[4*i+3], rmem[4*i+2], rmem[4*i+1], rmem[4*i]});
    endtask

    // One request from IDLE; entered and left at posedge+1
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        int          s;
        logic        legal;
        logic        strad;
        logic [31:0] exp_ld;
        logic [31:0] a_word;
        s      = sz(f3);
        legal  = we ? (f3 <= 3'd2) : (s != 0);
        strad  = legal && (int'(addr[1:0]) + s > 4);
        exp_ld = (legal && !we) ? ref_load(f3, addr) : 32'd0;
        a_word = {addr[31:2], 2'b00};
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #4;
        if (!legal) begin
            check_eq("illegal.fault", fault, 1);
            check_eq("illegal.rsp_valid", rsp_valid, 1);
            check_eq("illegal.rdata", rsp_rdata, 0);
            check_eq("illegal.mem_we", mem_we, 0);
            check_eq("illegal.busy", busy, 0);
        end else if (strad) begin
            check_eq("split1.busy", busy, 1);
            check_eq("split1.rsp_valid", rsp_valid, 0);
            check_eq("split1.fault", fault, 0);
            check_eq("split1.mem_addr", mem_addr, a_word);
            check_eq("split1.mem_we", mem_we, we);
            check_eq("nf.fault", nf_fault, 1);
            check_eq("nf.mem_we", nf_mem_we, 0);
            check_eq("nf.busy", nf_busy, 0);
            check_eq("nf.rdata", nf_rsp_rdata, 0);
            @(posedge clk);
            #1;
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_funct3 = 3'($urandom);
            req_we     = 1'($urandom);
            #4;
            check_eq("split2.busy", busy, 0);
            check_eq("split2.rsp_valid", rsp_valid, 1);
            check_eq("split2.mem_addr", mem_addr, a_word + 32'd4);
            check_eq("split2.mem_we", mem_we, we);
            check_eq("split2.rdata", rsp_rdata, exp_ld);
        end else begin
            check_eq("single.busy", busy, 0);
            check_eq("single.rsp_valid", rsp_valid, 1);
            check_eq("single.fault", fault, 0);
            check_eq("single.mem_addr", mem_addr, a_word);
            check_eq("single.mem_we", mem_we, we);
            check_eq("single.rdata", rsp_rdata, exp_ld);
        end
        if (legal && we) ref_store(addr, wd, s);
        @(posedge clk);
        #1 req_valid = 1'b0;
        compare_mem();
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".busy"}, busy, 0);
        check_eq({tag, ".rsp_valid"}, rsp_valid, 0);
        check_eq({tag, ".fault"}, fault, 0);
        check_eq({tag, ".mem_we"}, mem_we, 0);
        check_eq({tag, ".rdata"}, rsp_rdata, 0);
        check_eq({tag, ".mem_addr"}, mem_addr, 0);
        check_eq({tag, ".mem_wd"}, mem_wd, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0001;
        req_wdata  = 32'hFFFF_FFFF;
        bk_we      = 1'b0;
        bk_idx     = 4'd0;
        bk_data    = 32'd0;
        #1;
        for (int i = 0; i < 16; i++) bk_write(4'(i), 32'd0);
        #4 check_quiet("reset");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        #4 check_quiet("idle");
        @(posedge clk);
        #1;

        // Sub-word loads
        bk_write(4'd0, 32'hFACE_FACE);
        bk_write(4'd1, 32'h0000_0002);
        do_req(1'b0, 3'd0, 32'd1, 32'd0);
        do_req(1'b0, 3'd4, 32'd1, 32'd0);
        do_req(1'b0, 3'd1, 32'd0, 32'd0);
        do_req(1'b0, 3'd5, 32'd2, 32'd0);
        // Byte and word stores
        do_req(1'b1, 3'd0, 32'd2, 32'h0000_00AB);
        check_eq("sb.word0", mem[0], 32'hFAAB_FACE);
        do_req(1'b1, 3'd2, 32'd4, 32'h1122_3344);
        check_eq("sw.word1", mem[1], 32'h1122_3344);
        // Straddling load and store
        bk_write(4'd0, 32'hFACE_FACE);
        bk_write(4'd1, 32'h0000_0002);
        do_req(1'b0, 3'd2, 32'd2, 32'd0);
        do_req(1'b1, 3'd1, 32'd3, 32'h0000_1234);
        check_eq("sh.word0", mem[0], 32'h34CE_FACE);
        check_eq("sh.word1", mem[1], 32'h0000_0012);
        // Address wrap and illegal encodings
        do_req(1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0);
        do_req(1'b0, 3'd3, 32'd0, 32'd0);
        do_req(1'b1, 3'd4, 32'd0, 32'h5555_5555);
        do_req(1'b0, 3'd6, 32'd5, 32'd0);
        do_req(1'b1, 3'd7, 32'd6, 32'hAAAA_AAAA);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            do_req(1'($urandom), 3'($urandom), $urandom, $urandom);
            if (($urandom % 8) == 0) begin
                #4 check_quiet("gap");
                @(posedge clk);
                #1;
            end
        end

        // Reset while in SECOND of a straddling store
        bk_write(4'd0, 32'hFACE_FACE);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'd1;
        req_wdata  = 32'hDEAD_BEEF;
        #4 check_eq("rst_split.busy", busy, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        ref_store(32'd1, 32'hDEAD_BEEF, 3);
        #3 check_quiet("rst_second");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        check_eq("rst_split.word0", mem[0], 32'hADBE_EFCE);
        compare_mem();
        do_req(1'b0, 3'd2, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_align_unit.md
# lsu_align_unit

Load/store alignment unit between the core's execute stage and the word-only `data_memory` (synchronous word write, asynchronous word read, no byte enables). It extracts and sign/zero-extends sub-word loads and performs read-modify-write merging for SB/SH. It also splits accesses that straddle a word boundary into two consecutive word accesses, stalling the core for one cycle. Memory-side ports connect directly to `data_memory` `we`/`addr`/`wd`/`rd`.

## Interface
- `MISALIGN_EN`, 1: 1 = split straddling accesses; 0 = flag them as `fault`, no memory access.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: memory instruction present this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (loads 000/001/010/100/101; stores 000/001/010).
- `req_addr` in 32: byte address from ALU.
- `req_wdata` in 32: store data (rs2).
- `busy` out 1: core stall (PC/pipeline hold); core keeps `req_*` stable while high.
- `rsp_valid` out 1: access completes this cycle; load result valid.
- `rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `fault` out 1: illegal funct3 or (MISALIGN_EN=0 and straddling), one cycle.
- `mem_we` out 1, `mem_addr` out 32 (word-aligned, [1:0]=0), `mem_wd` out 32, `mem_rd` in 32.

## Operation
- Little-endian: byte at offset o of word = bits [8o+7:8o]; o = `req_addr[1:0]`.
- Size: B=1, H=2, W=4 bytes. Straddling iff o+size > 4 (LH/SH o=3; LW/SW o=1..3).
- Non-straddling: single cycle. `mem_addr`={addr[31:2],2'b00}. Loads: lanes extracted from `mem_rd`, LB/LH sign-extend, LBU/LHU zero-extend. Stores: `mem_wd` = `mem_rd` with target lanes replaced by low bytes of `req_wdata`; `mem_we`=1; written at the edge.
- Straddling: FSM states IDLE, SECOND.
  - IDLE (accept cycle): `busy`=1, word A = addr&~3. Load: latch bytes o..3 of `mem_rd` into `hold`. Store: write A with low (4-o) bytes of data into lanes o..3. Latch addr/funct3/wdata/we. -> SECOND.
  - SECOND: `busy`=0, word B = A+4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000). Load: result = {mem_rd lanes 0..(o+size-5), hold}, extended; `rsp_valid`=1. Store: write B with remaining bytes into lanes 0..(o+size-5), other lanes from `mem_rd`. `req_*` ignored. -> IDLE.
- Fault: illegal funct3 (load 011/110/111, store >=011), or straddling with MISALIGN_EN=0: `fault`=1, `rsp_valid`=1, `mem_we`=0, `rsp_rdata`=0, no state change.
- `req_valid`=0 in IDLE: all outputs 0 except `mem_addr` (don't-care, drive 0).

## Timing
- Reset (rst_n low, any state): state IDLE, `hold`/latched request 0; `busy`, `rsp_valid`, `fault`, `mem_we`, `rsp_rdata`, `mem_addr`, `mem_wd` forced 0.
- Reset during SECOND: second word not written; first-word store already committed (partial store is accepted behaviour).
- Latency: aligned/non-straddling = 0 extra cycles (combinational result, write at accept edge); straddling = 1 extra cycle, `busy` high exactly one cycle.
- `mem_we` never high in two consecutive cycles for different requests without an intervening core advance; at most two writes per store.
- Read-modify-write relies on asynchronous `mem_rd` for the same `mem_addr` in the same cycle.

## Structure
- Shared header `lsu_pkg.vh`: funct3 localparams (F3_B/H/W/BU/HU), state encodings ST_IDLE/ST_SECOND, size decode.
- Sub-module `lsu_lane_merge` (combinational): lane extract + extend for loads, lane insert for stores, given offset, size, and half (first/second).
- Top holds the FSM, `hold` register, and latched request.

## Test plan
- Memory word0=0xFACEFACE, word1=0x00000002. LB @1 -> 0xFFFFFFFA; LBU @1 -> 0x000000FA; LH @0 -> 0xFFFFFACE; LHU @2 -> 0x0000FACE; all `busy`=0, `rsp_valid`=1.
- SB 0x000000AB @2 -> word0 = 0xFAABFACE, single `mem_we` pulse; SW 0x11223344 @4 -> word1 = 0x11223344.
- LW @2 -> `busy`=1 for one cycle, `mem_addr` 0 then 4, `rsp_rdata`=0x0002FACE in cycle 2. SH 0x1234 @3 -> word0 = 0x34CEFACE, word1 = 0x00000012.
- Wrap: LW @0xFFFFFFFE (MISALIGN_EN=1) -> second `mem_addr`=0x00000000; with MISALIGN_EN=0 -> `fault`=1, no `mem_we`, `busy`=0.
- Illegal: load funct3=011 or store funct3=100 -> `fault`=1, `rsp_rdata`=0, memory unchanged.
- SW 0xDEADBEEF @1 with `rst_n` asserted in SECOND -> word0 = 0xADBEEFCE, word1 unchanged, all outputs 0, next request handled from IDLE.
